// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the shared-SPRAM arbiter.
// HTRANS/HRESP/HBURST constants plus small transfer-type helpers.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  function automatic logic is_cont(input logic [1:0] t);
    return (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
  endfunction

  function automatic logic is_act(input logic [1:0] t);
    return t != HTRANS_IDLE;
  endfunction

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// Combinational round-robin priority encoder.
// Lowest requester at or after ptr_i wins, wrapping modulo N.
module mpsoc_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_any_o
);

  int j;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!gnt_any_o && req_i[j]) begin
        gnt_any_o   = 1'b1;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = W'(j);
      end
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_spram_arbiter.sv
// Round-robin AHB3-Lite arbiter sharing one SPRAM slave between masters.
// Bursts and locked sequences are never split; losers stall on HREADYOUT.
module mpsoc_ahb3_spram_arbiter
  import mpsoc_ahb3_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int PLEN    = 32,
  parameter int XLEN    = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,

  input  logic [MASTERS-1:0]            m_HSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]  m_HADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]  m_HWDATA,
  output logic [MASTERS-1:0][XLEN-1:0]  m_HRDATA,
  input  logic [MASTERS-1:0]            m_HWRITE,
  input  logic [MASTERS-1:0][2:0]       m_HSIZE,
  input  logic [MASTERS-1:0][2:0]       m_HBURST,
  input  logic [MASTERS-1:0][3:0]       m_HPROT,
  input  logic [MASTERS-1:0][1:0]       m_HTRANS,
  input  logic [MASTERS-1:0]            m_HMASTLOCK,
  output logic [MASTERS-1:0]            m_HREADYOUT,
  output logic [MASTERS-1:0]            m_HRESP,

  output logic                          s_HSEL,
  output logic [PLEN-1:0]               s_HADDR,
  output logic [XLEN-1:0]               s_HWDATA,
  input  logic [XLEN-1:0]               s_HRDATA,
  output logic                          s_HWRITE,
  output logic [2:0]                    s_HSIZE,
  output logic [2:0]                    s_HBURST,
  output logic [3:0]                    s_HPROT,
  output logic [1:0]                    s_HTRANS,
  output logic                          s_HMASTLOCK,
  output logic                          s_HREADY,
  input  logic                          s_HREADYOUT,
  input  logic                          s_HRESP
);

  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MW-1:0] aowner_q, aowner_d;
  logic [MW-1:0] downer_q, downer_d;
  logic [MW-1:0] rr_ptr_q, rr_ptr_d;
  logic          dvalid_q, dvalid_d;
  logic          locked_q, locked_d;
  logic          hold_q, hold_d;

  logic [MASTERS-1:0] req, act, gnt_oh;
  logic [MW-1:0]      win, win_nxt;
  logic               win_any;
  logic [1:0]         own_trans;
  logic               own_cont, arb_en, regrant, fwd;

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      act[i] = m_HSEL[i] && is_act(m_HTRANS[i]);
      req[i] = m_HSEL[i] && (m_HTRANS[i] == HTRANS_NONSEQ);
    end
  end

  mpsoc_rr_arbiter #(
    .N (MASTERS),
    .W (MW)
  ) u_rr (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (win),
    .gnt_any_o (win_any)
  );

  assign win_nxt   = (win == MW'(MASTERS - 1)) ? '0 : win + MW'(1);
  assign own_trans = m_HTRANS[aowner_q];
  assign own_cont  = m_HSEL[aowner_q] &&
                     (is_cont(own_trans) || m_HMASTLOCK[aowner_q]);

  // hold_q keeps a fresh grant stable until its first address is taken
  assign arb_en  = s_HREADYOUT && !locked_q && !hold_q &&
                   !own_cont && win_any;
  assign regrant = arb_en && !gnt_oh[aowner_q];
  assign fwd     = HRESETn && !regrant && act[aowner_q];

  assign s_HSEL      = HRESETn && m_HSEL[aowner_q];
  assign s_HTRANS    = fwd ? own_trans : HTRANS_IDLE;
  assign s_HADDR     = m_HADDR[aowner_q];
  assign s_HWRITE    = m_HWRITE[aowner_q];
  assign s_HSIZE     = m_HSIZE[aowner_q];
  assign s_HBURST    = m_HBURST[aowner_q];
  assign s_HPROT     = m_HPROT[aowner_q];
  assign s_HMASTLOCK = m_HMASTLOCK[aowner_q];
  assign s_HREADY    = s_HREADYOUT;
  assign s_HWDATA    = m_HWDATA[downer_q];
  assign m_HRDATA    = {MASTERS{s_HRDATA}};

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      m_HREADYOUT[i] = 1'b1;
      m_HRESP[i]     = HRESP_OKAY;
      if (HRESETn) begin
        if (dvalid_q && downer_q == MW'(i)) begin
          m_HREADYOUT[i] = s_HREADYOUT;
          m_HRESP[i]     = s_HRESP;
        end else if (fwd && aowner_q == MW'(i)) begin
          m_HREADYOUT[i] = s_HREADYOUT;
        end else if (act[i]) begin
          m_HREADYOUT[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    aowner_d = aowner_q;
    rr_ptr_d = rr_ptr_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    locked_d = locked_q;
    hold_d   = hold_q && !s_HREADYOUT;
    if (arb_en) rr_ptr_d = win_nxt;
    if (regrant) begin
      aowner_d = win;
      hold_d   = 1'b1;
    end
    if (s_HREADYOUT) begin
      dvalid_d = fwd;
      locked_d = fwd && m_HMASTLOCK[aowner_q];
      if (fwd) downer_d = aowner_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aowner_q <= '0;
      downer_q <= '0;
      rr_ptr_q <= '0;
      dvalid_q <= 1'b0;
      locked_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      aowner_q <= aowner_d;
      downer_q <= downer_d;
      rr_ptr_q <= rr_ptr_d;
      dvalid_q <= dvalid_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_mpsoc_ahb3_spram_arbiter.sv
// Directed bench for the shared-SPRAM AHB3-Lite arbiter.
// A small memory stub stands in for the SPRAM slave.
module tb_mpsoc_ahb3_spram_arbiter;
  import mpsoc_ahb3_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  logic [3:0]       m_HSEL, m_HWRITE, m_HMASTLOCK;
  logic [3:0][31:0] m_HADDR, m_HWDATA, m_HRDATA;
  logic [3:0][2:0]  m_HSIZE, m_HBURST;
  logic [3:0][3:0]  m_HPROT;
  logic [3:0][1:0]  m_HTRANS;
  logic [3:0]       m_HREADYOUT, m_HRESP;

  logic        s_HSEL, s_HWRITE, s_HMASTLOCK, s_HREADY;
  logic [31:0] s_HADDR, s_HWDATA, s_HRDATA;
  logic [2:0]  s_HSIZE, s_HBURST;
  logic [3:0]  s_HPROT;
  logic [1:0]  s_HTRANS;
  logic        s_HREADYOUT = 1'b1;
  logic        s_HRESP = 1'b0;

  int tests = 0;
  int fails = 0;
  int n, cyc, expm, got;
  int cnt [4];

  always #5 HCLK = ~HCLK;

  mpsoc_ahb3_spram_arbiter #(
    .MASTERS (4),
    .PLEN    (32),
    .XLEN    (32)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .m_HSEL      (m_HSEL),
    .m_HADDR     (m_HADDR),
    .m_HWDATA    (m_HWDATA),
    .m_HRDATA    (m_HRDATA),
    .m_HWRITE    (m_HWRITE),
    .m_HSIZE     (m_HSIZE),
    .m_HBURST    (m_HBURST),
    .m_HPROT     (m_HPROT),
    .m_HTRANS    (m_HTRANS),
    .m_HMASTLOCK (m_HMASTLOCK),
    .m_HREADYOUT (m_HREADYOUT),
    .m_HRESP     (m_HRESP),
    .s_HSEL      (s_HSEL),
    .s_HADDR     (s_HADDR),
    .s_HWDATA    (s_HWDATA),
    .s_HRDATA    (s_HRDATA),
    .s_HWRITE    (s_HWRITE),
    .s_HSIZE     (s_HSIZE),
    .s_HBURST    (s_HBURST),
    .s_HPROT     (s_HPROT),
    .s_HTRANS    (s_HTRANS),
    .s_HMASTLOCK (s_HMASTLOCK),
    .s_HREADY    (s_HREADY),
    .s_HREADYOUT (s_HREADYOUT),
    .s_HRESP     (s_HRESP)
  );

  // memory stub: write data lands at the end of the data phase
  logic [31:0] mem [64];
  logic        dp_w;
  logic [5:0]  dp_a;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_w <= 1'b0;
      dp_a <= '0;
    end else if (s_HREADYOUT) begin
      if (dp_w) mem[dp_a] <= s_HWDATA;
      dp_w <= s_HSEL && s_HTRANS[1] && s_HWRITE;
      dp_a <= s_HADDR[7:2];
    end
  end

  assign s_HRDATA = mem[dp_a];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic setm(input int i, input logic sel, input logic [1:0] tr,
                      input logic w, input logic lk, input logic [2:0] bu,
                      input logic [31:0] a);
    m_HSEL[i]      = sel;
    m_HTRANS[i]    = tr;
    m_HWRITE[i]    = w;
    m_HMASTLOCK[i] = lk;
    m_HBURST[i]    = bu;
    m_HADDR[i]     = a;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++)
      setm(i, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
  endtask

  initial begin
    m_HWDATA = '0;
    m_HSIZE  = {4{3'b010}};
    m_HPROT  = {4{4'b0011}};
    idle_all();

    // reset: outputs gated even with master 0 requesting
    setm(0, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 32'h10);
    #3;
    chk("rst_htrans", s_HTRANS, HTRANS_IDLE);
    chk("rst_hsel", s_HSEL, 1'b0);
    chk("rst_hreadyout", m_HREADYOUT, 4'hF);
    chk("rst_hresp", m_HRESP, 4'h0);
    tick();
    tick();
    HRESETn = 1'b1;

    // C0: parked master 0 write, zero latency
    #1;
    chk("p0_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("p0_haddr", s_HADDR, 32'h10);
    chk("p0_ready", m_HREADYOUT, 4'hF);
    tick();
    // C1: data phase + pipelined read of same address
    m_HWDATA[0] = 32'hA5A5_0001;
    setm(0, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_SINGLE, 32'h10);
    #1;
    chk("p0_hwdata", s_HWDATA, 32'hA5A5_0001);
    chk("p0_rd_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("p0_rd_hwrite", s_HWRITE, 1'b0);
    tick();
    // C2: read data
    setm(0, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    #1;
    chk("p0_rdata", m_HRDATA[0], 32'hA5A5_0001);
    chk("p0_rd_ready", m_HREADYOUT[0], 1'b1);
    tick();

    // C3: masters 1 and 2 collide while 0 is parked
    setm(1, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 32'h20);
    setm(2, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 32'h24);
    #1;
    chk("c12_regrant", s_HTRANS, HTRANS_IDLE);
    chk("c12_stall", m_HREADYOUT, 4'b1001);
    tick();
    // C4: master 1 forwarded
    #1;
    chk("c12_m1_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("c12_m1_haddr", s_HADDR, 32'h20);
    chk("c12_m1_ready", m_HREADYOUT, 4'b1011);
    tick();
    // C5: master 1 data, re-grant to 2
    setm(1, 1'b1, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    m_HWDATA[1] = 32'hD1D1_0001;
    #1;
    chk("c12_m1_hwdata", s_HWDATA, 32'hD1D1_0001);
    chk("c12_regrant2", s_HTRANS, HTRANS_IDLE);
    chk("c12_m2_stall", m_HREADYOUT, 4'b1011);
    tick();
    // C6: master 2 forwarded
    #1;
    chk("c12_m2_haddr", s_HADDR, 32'h24);
    chk("c12_m2_ready", m_HREADYOUT, 4'hF);
    tick();
    // C7: master 2 data
    setm(2, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    m_HWDATA[2] = 32'hD2D2_0002;
    #1;
    chk("c12_m2_hwdata", s_HWDATA, 32'hD2D2_0002);
    tick();
    setm(1, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);

    // C8: master 3 INCR4 vs master 0
    setm(3, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h40);
    setm(0, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_SINGLE, 32'h10);
    #1;
    chk("b_regrant", s_HTRANS, HTRANS_IDLE);
    chk("b_stall", m_HREADYOUT, 4'b0110);
    tick();
    // C9: beat 0
    #1;
    chk("b_beat0", s_HTRANS, HTRANS_NONSEQ);
    chk("b_hburst", s_HBURST, HBURST_INCR4);
    chk("b_beat0_ready", m_HREADYOUT, 4'b1110);
    tick();
    // C10: beat 1
    setm(3, 1'b1, HTRANS_SEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h44);
    #1;
    chk("b_beat1", s_HTRANS, HTRANS_SEQ);
    chk("b_beat1_addr", s_HADDR, 32'h44);
    tick();
    // C11: beat 2 under a slave wait state
    setm(3, 1'b1, HTRANS_SEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h48);
    s_HREADYOUT = 1'b0;
    #1;
    chk("b_wait_htrans", s_HTRANS, HTRANS_SEQ);
    chk("b_wait_ready", m_HREADYOUT, 4'b0110);
    tick();
    // C12: beat 2 accepted
    s_HREADYOUT = 1'b1;
    #1;
    chk("b_beat2_addr", s_HADDR, 32'h48);
    tick();
    // C13: beat 3
    setm(3, 1'b1, HTRANS_SEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h4C);
    #1;
    chk("b_beat3", s_HTRANS, HTRANS_SEQ);
    chk("b_beat3_m0", m_HREADYOUT[0], 1'b0);
    tick();
    // C14: burst done, re-grant to 0
    setm(3, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    #1;
    chk("b_m0_regrant", s_HTRANS, HTRANS_IDLE);
    chk("b_m0_stall", m_HREADYOUT, 4'b1110);
    tick();
    // C15: master 0 read forwarded
    #1;
    chk("b_m0_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("b_m0_haddr", s_HADDR, 32'h10);
    tick();
    // C16: read data
    setm(0, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    #1;
    chk("b_m0_rdata", m_HRDATA[0], 32'hA5A5_0001);
    tick();

    // C17: master 1 locked read, master 2 competing
    setm(1, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b1, HBURST_SINGLE, 32'h20);
    setm(2, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 32'h24);
    #1;
    chk("l_regrant", s_HTRANS, HTRANS_IDLE);
    tick();
    // C18: locked read forwarded
    #1;
    chk("l_rd_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("l_rd_lock", s_HMASTLOCK, 1'b1);
    chk("l_rd_ready", m_HREADYOUT, 4'b1011);
    tick();
    // C19: locked write
    setm(1, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b1, HBURST_SINGLE, 32'h28);
    #1;
    chk("l_rdata", m_HRDATA[1], 32'hD1D1_0001);
    chk("l_wr_addr", s_HADDR, 32'h28);
    chk("l_wr_write", s_HWRITE, 1'b1);
    chk("l_wr_ready", m_HREADYOUT, 4'b1011);
    tick();
    // C20: unlocked read still belongs to master 1
    setm(1, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_SINGLE, 32'h28);
    m_HWDATA[1] = 32'hD3D3_0003;
    #1;
    chk("l_unlk_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("l_unlk_lock", s_HMASTLOCK, 1'b0);
    chk("l_unlk_m2", m_HREADYOUT[2], 1'b0);
    tick();
    // C21: grant moves to 2
    setm(1, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    #1;
    chk("l_regrant2", s_HTRANS, HTRANS_IDLE);
    chk("l_rdata2", m_HRDATA[1], 32'hD3D3_0003);
    tick();
    // C22: master 2 forwarded
    #1;
    chk("l_m2_haddr", s_HADDR, 32'h24);
    chk("l_m2_htrans", s_HTRANS, HTRANS_NONSEQ);
    tick();
    setm(2, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    tick();

    // four masters requesting continuously; pointer now sits at 3
    for (int i = 0; i < 4; i++) begin
      setm(i, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_SINGLE,
           32'h100 + 32'(i) * 32'd4);
      cnt[i] = 0;
    end
    n = 0;
    cyc = 0;
    expm = 3;
    while (n < 40 && cyc < 200) begin
      #1;
      if (s_HTRANS == HTRANS_NONSEQ) begin
        got = int'(s_HADDR[3:2]);
        chk("rr_order", 64'(got), 64'(expm));
        cnt[got] = cnt[got] + 1;
        expm = (expm + 1) % 4;
        n++;
      end
      tick();
      cyc++;
    end
    idle_all();
    chk("rr_total", 64'(n), 64'd40);
    for (int i = 0; i < 4; i++) chk("rr_share", 64'(cnt[i]), 64'd10);
    tick();

    // reset pulsed in the middle of a master 3 burst
    setm(3, 1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h80);
    #1;
    chk("r_regrant", s_HTRANS, HTRANS_IDLE);
    tick();
    tick();
    setm(3, 1'b1, HTRANS_SEQ, 1'b0, 1'b0, HBURST_INCR4, 32'h84);
    #1;
    chk("r_beat1", s_HTRANS, HTRANS_SEQ);
    HRESETn = 1'b0;
    #1;
    chk("r_htrans", s_HTRANS, HTRANS_IDLE);
    chk("r_hsel", s_HSEL, 1'b0);
    chk("r_hreadyout", m_HREADYOUT, 4'hF);
    chk("r_hresp", m_HRESP, 4'h0);
    idle_all();
    tick();
    tick();
    HRESETn = 1'b1;
    setm(0, 1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 32'h14);
    #1;
    chk("r_m0_htrans", s_HTRANS, HTRANS_NONSEQ);
    chk("r_m0_haddr", s_HADDR, 32'h14);
    chk("r_m0_ready", m_HREADYOUT, 4'hF);
    tick();

    // two-cycle ERROR response passes through to the data owner
    setm(0, 1'b0, HTRANS_IDLE, 1'b0, 1'b0, HBURST_SINGLE, 32'h0);
    s_HREADYOUT = 1'b0;
    s_HRESP = 1'b1;
    #1;
    chk("e1_ready", m_HREADYOUT, 4'b1110);
    chk("e1_resp", m_HRESP, 4'b0001);
    tick();
    s_HREADYOUT = 1'b1;
    #1;
    chk("e2_ready", m_HREADYOUT, 4'hF);
    chk("e2_resp", m_HRESP, 4'b0001);
    tick();
    s_HRESP = 1'b0;
    #1;
    chk("e3_resp", m_HRESP, 4'h0);
    chk("e3_htrans", s_HTRANS, HTRANS_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
